// File: rtl/regfile_sb.sv
// Multi-port integer register file with same-cycle write bypass, hardwired x0,
// and a per-register saturating pending-write scoreboard for RAW hazard detection.
module regfile_sb #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NREAD      = 2,
  parameter int NWRITE     = 2,
  parameter int CNT_WIDTH  = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NREAD*ADDR_WIDTH-1:0]  raddr,
  output logic [NREAD*DATA_WIDTH-1:0]  rdata,
  output logic [NREAD-1:0]             rbusy,
  input  logic [NWRITE-1:0]            wen,
  input  logic [NWRITE*ADDR_WIDTH-1:0] waddr,
  input  logic [NWRITE*DATA_WIDTH-1:0] wdata,
  input  logic [NWRITE-1:0]            wretire,
  input  logic                         claim_valid,
  input  logic [ADDR_WIDTH-1:0]        claim_addr,
  output logic                         claim_ready,
  output logic                         sb_err
);

  localparam int NREG = 2 ** ADDR_WIDTH;
  localparam int EW   = CNT_WIDTH + 2;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [DATA_WIDTH-1:0] r_rf  [NREG];
  logic [CNT_WIDTH-1:0]  r_cnt [NREG];
  logic                  r_sbErr;

  logic [ADDR_WIDTH-1:0] w_raddr   [NREAD];
  logic [ADDR_WIDTH-1:0] w_waddr   [NWRITE];
  logic [DATA_WIDTH-1:0] w_wdata   [NWRITE];
  logic [EW-1:0]         w_dec     [NREG];
  logic [EW-1:0]         w_sum     [NREG];
  logic [CNT_WIDTH-1:0]  w_cntNext [NREG];
  logic                  w_errSet;
  logic                  w_claimAcc;

  always_comb begin
    for (int i = 0; i < NREAD; i++) w_raddr[i] = raddr[i*ADDR_WIDTH +: ADDR_WIDTH];
    for (int j = 0; j < NWRITE; j++) begin
      w_waddr[j] = waddr[j*ADDR_WIDTH +: ADDR_WIDTH];
      w_wdata[j] = wdata[j*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Ready looks only at the registered count so decode never sees a retire-dependent path.
  assign claim_ready = rst || (claim_addr == '0) || (r_cnt[claim_addr] != CNT_MAX);
  assign w_claimAcc  = claim_valid && claim_ready && !rst;
  assign sb_err      = r_sbErr;

  always_comb begin
    for (int r = 0; r < NREG; r++) w_dec[r] = '0;
    for (int r = 1; r < NREG; r++)
      for (int j = 0; j < NWRITE; j++)
        if (wen[j] && wretire[j] && (w_waddr[j] == ADDR_WIDTH'(r)))
          w_dec[r] = w_dec[r] + EW'(1);
  end

  always_comb begin
    w_errSet = 1'b0;
    for (int r = 0; r < NREG; r++) begin
      w_sum[r]     = '0;
      w_cntNext[r] = '0;
    end
    for (int r = 1; r < NREG; r++) begin
      w_sum[r] = EW'(r_cnt[r]) +
                 ((w_claimAcc && (claim_addr == ADDR_WIDTH'(r))) ? EW'(1) : EW'(0));
      if (w_dec[r] > w_sum[r]) begin
        w_cntNext[r] = '0;
        w_errSet     = 1'b1;
      end else begin
        w_cntNext[r] = CNT_WIDTH'(w_sum[r] - w_dec[r]);
      end
    end
  end

  // Later write ports override earlier ones for both bypass and storage.
  always_comb begin
    rdata = '0;
    rbusy = '0;
    for (int i = 0; i < NREAD; i++) begin
      rdata[i*DATA_WIDTH +: DATA_WIDTH] = r_rf[w_raddr[i]];
      for (int j = 0; j < NWRITE; j++)
        if (wen[j] && (w_waddr[j] == w_raddr[i]))
          rdata[i*DATA_WIDTH +: DATA_WIDTH] = w_wdata[j];
      if (rst || (w_raddr[i] == '0))
        rdata[i*DATA_WIDTH +: DATA_WIDTH] = '0;
      rbusy[i] = !rst && (EW'(r_cnt[w_raddr[i]]) > w_dec[w_raddr[i]]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        r_rf[r]  <= '0;
        r_cnt[r] <= '0;
      end
      r_sbErr <= 1'b0;
    end else begin
      for (int j = 0; j < NWRITE; j++)
        if (wen[j] && (w_waddr[j] != '0))
          r_rf[w_waddr[j]] <= w_wdata[j];
      for (int r = 0; r < NREG; r++) r_cnt[r] <= w_cntNext[r];
      if (w_errSet) r_sbErr <= 1'b1;
    end
  end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised multi-port integer register file with per-register pending-write scoreboard, for the 5-stage core's decode/writeback boundary. It has NREAD combinational read ports and NWRITE write ports, with same-cycle write-to-read bypass and a hardwired-zero x0. Decode uses a saturating in-flight counter per register to detect RAW hazards. A claim handshake stalls issue when a counter saturates.

## Interface
- DATA_WIDTH, 32, register width
- ADDR_WIDTH, 5, register index width; 2**ADDR_WIDTH registers
- NREAD, 2, read ports (1..4)
- NWRITE, 2, write ports (1..2)
- CNT_WIDTH, 2, scoreboard counter width per register (1..3)
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- raddr  in  NREAD*ADDR_WIDTH  read indices; port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- rdata  out  NREAD*DATA_WIDTH  read data, packed the same way
- rbusy  out  NREAD  register still has unretired pending writes
- wen  in  NWRITE  write enable per port
- waddr  in  NWRITE*ADDR_WIDTH  write indices
- wdata  in  NWRITE*DATA_WIDTH  write data
- wretire  in  NWRITE  this write retires one scoreboard claim; ignored unless wen
- claim_valid  in  1  decode requests to mark claim_addr pending
- claim_addr  in  ADDR_WIDTH  destination being claimed
- claim_ready  out  1  claim can be accepted this cycle
- sb_err  out  1  sticky: retire hit a zero counter

## Operation
- Storage: rf[0..2**ADDR_WIDTH-1] of DATA_WIDTH, and cnt[0..2**ADDR_WIDTH-1] of CNT_WIDTH.
- Write: on the rising edge, if wen[j] and waddr[j]!=0, then rf[waddr[j]] <= wdata[j].
  - Two ports to the same address: the highest-index port wins.
- Read (combinational): rdata[i] = 0 if raddr[i]==0.
  - Otherwise, wdata of the highest-index port j with wen[j] and waddr[j]==raddr[i].
  - Otherwise, rf[raddr[i]].
- Scoreboard per register r: inc = claim accepted with claim_addr==r. dec = number of ports with wen&wretire targeting r.
  - Next cnt = cnt + inc − dec, clamped at 0.
  - If dec > cnt+inc, set sb_err. sb_err stays set until rst.
- claim accepted = claim_valid & claim_ready.
- claim_ready = 1 if claim_addr==0; otherwise (cnt[claim_addr] != 2**CNT_WIDTH−1). It depends on the registered count only, not same-cycle retires.
- Claims to x0 are always ready and never change state. x0's cnt stays 0, and rbusy for x0 is 0.
- rbusy[i] = cnt[raddr[i]] > dec(raddr[i]) in this cycle. A same-cycle retire clears busy in the same cycle, matching the bypassed data.
- Retire with waddr 0: no counter change, no error.

## Timing
- Reads, bypass, rbusy and claim_ready are combinational, with zero latency.
- Register and counter updates are visible the cycle after the write/claim edge.
- While rst is high:
  - all rf = 0, all cnt = 0, sb_err = 0;
  - bypass suppressed, so rdata = 0 and rbusy = 0;
  - claim_ready = 1;
  - writes and claims are ignored.
- Reset deassertion mid-operation: state restarts from zero. Outstanding claims are lost, and their later retires set sb_err.
- Simultaneous claim and retire to the same register: the count is unchanged.
- A claim at saturation is not accepted. Decode holds claim_valid until ready, and no state changes.

## Test plan
- Reset, then read r5/r0 -> rdata 0, rbusy 0, claim_ready 1, sb_err 0.
- Write port0 r3=0xDEADBEEF with raddr0=3 the same cycle -> rdata0=0xDEADBEEF combinationally; next cycle stored.
- Both ports write r7 (0x11 on port0, 0x22 on port1) -> bypass and stored value 0x22. Write to r0 -> r0 reads 0.
- Claim r4 three times (CNT_WIDTH=2) -> cnt 3, claim_ready 0 on the 4th attempt. A retire write to r4 drops cnt to 2 next cycle; rbusy stays 1.
- cnt[r9]=1 with claim r9 and retire r9 in the same cycle -> cnt stays 1. Retire alone next -> rbusy drops in that same cycle, and cnt=0 afterwards.
- Retire r6 with cnt 0 -> sb_err=1, cnt stays 0. Assert rst asynchronously mid-cycle -> sb_err and all state clear immediately.
